// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: builds the 10-bit start/data/stop frame and paces
// the downstream shift register's load and shift strobes at BAUD_DIV cycles per bit.
module uart_tx_ctrl #(
  parameter int BAUD_DIV = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic [9:0] tx_frame,
  output logic       tx_load,
  output logic       tx_shift,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] dbg_state
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          baud_wrap;

  // A bit period ends on the last baud count while sending.
  assign baud_wrap = (state_q == S_SEND) && (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d = {1'b1, tx_data, 1'b0};
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        baud_d  = '0;
        bit_d   = 4'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (baud_wrap) begin
          baud_d = '0;
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      frame_q <= 10'h3FF;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

  // The tenth shift moves the stop bit out and ends the frame.
  assign tx_frame  = frame_q;
  assign tx_load   = (state_q == S_LOAD);
  assign tx_shift  = (state_q == S_LOAD) || baud_wrap;
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_done   = baud_wrap && (bit_q == 4'd9);
  assign dbg_state = state_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller sitting directly upstream of the 10-bit transmit shift register. Accepts a byte with a one-cycle start request, builds the 10-bit frame (start, 8 data bits LSB-first, stop), and produces the shift register's parallel-load and shift-enable strobes at the programmed baud rate. Reports busy and completion to the processor-side UART interface.

## Interface
- BAUD_DIV, 10416: clock cycles per bit period (100 MHz / 9600 baud); legal range ≥ 2.
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-low.
- tx_data  input  8  byte to transmit; sampled only when a start is accepted.
- tx_start  input  1  start request, level-sampled each cycle.
- tx_frame  output  10  frame to the shift register's parallel data input: {1'b1, byte, 1'b0}. Bit 0 is the start bit and is transmitted first.
- tx_load  output  1  drives the shift register's load select; high for exactly one cycle per frame.
- tx_shift  output  1  drives the shift register's enable; high on the load cycle and on each bit-period boundary.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when the frame's stop bit period ends.

## Operation
- Reset (rst=0 at an edge): state IDLE, baud counter 0, bit counter 0.
  - Output reset values: tx_frame=10'h3FF, tx_load=0, tx_shift=0, tx_busy=0, tx_done=0.
  - A reset mid-frame abandons the frame immediately. No done pulse is issued. The shift register shares rst and returns the line to idle.
- States:
  - IDLE: if tx_start=1, capture the frame register {1, tx_data, 0} and go to LOAD.
  - LOAD: one cycle. tx_load=1, tx_shift=1, tx_busy=1. Clear the baud counter and the bit counter. Go to SEND.
  - SEND: the baud counter counts 0..BAUD_DIV-1 and wraps.
    - On count==BAUD_DIV-1: tx_shift=1 and the bit counter increments.
    - On the 10th shift: tx_done=1 and go to IDLE.
- tx_frame is registered. It holds its value from the LOAD cycle until the next LOAD; it does not return to 3FF after a frame.
- tx_start is ignored in LOAD and SEND. Start is accepted only in IDLE, so there is a minimum 1-cycle IDLE gap between frames.
- The 10th shift shifts a 1 into the register output, so the line stays at idle 1.
- Width rules:
  - Baud counter width is $clog2(BAUD_DIV).
  - Bit counter is 4 bits, range 0..10, with no wrap inside a frame.
- tx_load is never high without tx_shift.
- tx_shift is never high in IDLE.

## Timing
- Let T be the cycle in which tx_start=1 is sampled in IDLE.
- T+1: LOAD. tx_frame updates this cycle, tx_load=tx_shift=1, tx_busy rises. The serial line shows the start bit from the T+2 edge.
- k-th shift pulse (k=1..10) occurs at cycle T+1+k·BAUD_DIV.
- After the LOAD edge, each bit is held on the line for exactly BAUD_DIV cycles.
- tx_done=1 only at T+1+10·BAUD_DIV, which is the same cycle as the 10th shift.
- tx_busy is high from T+1 through T+1+10·BAUD_DIV inclusive, and low from the following cycle.
- Earliest next accepted start is at T+2+10·BAUD_DIV; its LOAD follows one cycle later.
- Frame-to-frame period with tx_start held high: 10·BAUD_DIV+2 cycles.

## Test plan
- Reset values: hold rst=0 for 3 cycles with tx_start=1.
  - Required: tx_frame=3FF, tx_load=tx_shift=tx_busy=tx_done=0 throughout.
  - After rst=1: the first LOAD occurs one cycle after the first sampled start.
- Single frame, BAUD_DIV=4, tx_data=A5, start at T:
  - T+1: tx_frame=0x34A with tx_load=1.
  - tx_shift pulses at T+1, 5, 9, …, 41 (11 total).
  - tx_done only at T+41; tx_busy high T+1..T+41.
  - Shift register serial out, LSB-first: 0,1,0,1,0,0,1,0,1,1, then idle 1.
- Start while busy: tx_data=3C, start at T, then tx_data=FF with start at T+10.
  - The second request is ignored; tx_frame stays 0x278.
  - Exactly one done pulse at T+41.
- Back-to-back (BAUD_DIV=4): tx_start held high.
  - LOADs at T+1 and T+43; done pulses at T+41 and T+83.
  - The line is never low between the two stop/start boundaries except for the start bit.
- Reset mid-frame: assert rst=0 at T+20.
  - From the next edge: IDLE, all outputs at reset values, no tx_done pulse.
  - After release, a new start gives a full, correct frame.
- BAUD_DIV=2 boundary: start at T.
  - Shifts at T+1, 3, 5, …, 21; done at T+21.
  - tx_busy falls at T+22.
